// File: rtl/vga_pkg.sv
// Shared 640x480@60Hz raster constants and receiver state encoding.
// Used by the sync receiver and its edge detector.
package vga_pkg;

    localparam int HD = 640;
    localparam int HF = 16;
    localparam int HB = 48;
    localparam int HR = 96;
    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VB = 33;
    localparam int VR = 2;

    localparam int HT = 800;
    localparam int VT = 525;

    typedef enum logic [1:0] {
        SEARCH,
        TRACK,
        LOCKED
    } rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Falling-edge detector for one active-low sync line.
// Optional macro VGA_RX_SYNC_EN adds a two-flop synchronizer in front.
module vga_sync_edge
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_fall
);

    logic w_sync;
    logic r_prev;

`ifdef VGA_RX_SYNC_EN
    logic r_meta;
    logic r_sync;

    // Two-stage synchronizer, idles high like an inactive sync line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_sync;
            r_sync <= r_meta;
        end
    end

    assign w_sync = r_sync;
`else
    assign w_sync = i_sync;
`endif

    // Previous sample for the fall detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_sync;
        end
    end

    assign o_fall = r_prev & ~w_sync;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA 640x480 sync receiver: recovers pixel coordinates and timing lock.
// Define VGA_RX_SYNC_EN to synchronize asynchronous sync inputs.
module vga_sync_receiver
    import vga_pkg::*;
#(
    parameter int LOCK_FRAMES  = 2,
    parameter int TIMEOUT_MULT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       timing_err
);

    localparam int HP_W = $clog2(TIMEOUT_MULT * HT + 2);

    localparam logic [9:0] H_LOAD = 10'(HD + HF);
    localparam logic [9:0] H_MAX  = 10'(HT - 1);
    localparam logic [9:0] V_LOAD = 10'(VD + VF);
    localparam logic [9:0] V_MAX  = 10'(VT - 1);
    localparam logic [9:0] LINES  = 10'(VT);

    localparam logic [HP_W-1:0] HP_GOOD = HP_W'(HT - 1);
    localparam logic [HP_W-1:0] HP_TMO  = HP_W'(TIMEOUT_MULT * HT);
    localparam logic [HP_W-1:0] HP_SAT  = '1;
    localparam logic [9:0]      LC_SAT  = '1;
    localparam logic [3:0]      GOOD_LAST = 4'(LOCK_FRAMES - 1);

    logic w_h_fall;
    logic w_v_fall;

    logic [9:0]      r_h_cnt;
    logic [9:0]      r_v_cnt;
    logic [HP_W-1:0] r_hp_cnt;
    logic [9:0]      r_line_cnt;
    logic            r_h_seen;
    rx_state_t       r_state;
    logic [3:0]      r_good;
    logic            r_frame_bad;
    logic            r_locked;
    logic            r_frame_start;
    logic            r_err;

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_h_wrap;
    logic       w_h_bad;
    logic       w_tmo;
    logic       w_line_bad;
    logic       w_err;
    logic       w_to_search;
    logic       w_enter_lock;
    logic       w_lock_next;

    vga_sync_edge u_hedge (
        .clk    (clk),
        .rst    (rst),
        .i_sync (hsync_in),
        .o_fall (w_h_fall)
    );

    vga_sync_edge u_vedge (
        .clk    (clk),
        .rst    (rst),
        .i_sync (vsync_in),
        .o_fall (w_v_fall)
    );

    assign w_h_wrap = !w_h_fall && (r_h_cnt == H_MAX);

    assign w_h_next = w_h_fall ? H_LOAD :
                      w_h_wrap ? 10'd0  : r_h_cnt + 10'd1;

    assign w_v_next = w_v_fall ? V_LOAD :
                      !w_h_wrap ? r_v_cnt :
                      (r_v_cnt == V_MAX) ? 10'd0 : r_v_cnt + 10'd1;

    assign w_h_bad    = w_h_fall && r_h_seen && (r_hp_cnt != HP_GOOD);
    assign w_tmo      = !w_h_fall && (r_hp_cnt == HP_TMO);
    assign w_line_bad = w_v_fall && (r_state != SEARCH)
                        && (r_line_cnt != LINES);
    assign w_err      = w_h_bad || w_tmo || w_line_bad;

    assign w_to_search  = w_tmo || ((r_state == LOCKED) && w_err);
    assign w_enter_lock = (r_state == TRACK) && w_v_fall && !w_err
                          && !r_frame_bad && (r_good == GOOD_LAST);
    assign w_lock_next  = ((r_state == LOCKED) && !w_err) || w_enter_lock;

    // Raster position counters, resynchronized on every sync fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
        end
    end

    // Line period and lines-per-frame measurement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hp_cnt   <= '0;
            r_line_cnt <= '0;
            r_h_seen   <= 1'b0;
        end else begin
            if (w_h_fall) begin
                r_hp_cnt <= '0;
            end else if (r_hp_cnt != HP_SAT) begin
                r_hp_cnt <= r_hp_cnt + 1'b1;
            end

            if (w_v_fall) begin
                r_line_cnt <= w_h_fall ? 10'd1 : 10'd0;
            end else if (w_h_fall && (r_line_cnt != LC_SAT)) begin
                r_line_cnt <= r_line_cnt + 10'd1;
            end

            if (w_to_search) begin
                r_h_seen <= 1'b0;
            end else if (w_h_fall) begin
                r_h_seen <= 1'b1;
            end
        end
    end

    // Lock state machine with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= SEARCH;
            r_good        <= '0;
            r_frame_bad   <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_start <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_locked      <= w_lock_next;
            r_err         <= w_err;
            r_frame_start <= w_lock_next && (w_h_next == 10'd0)
                             && (w_v_next == 10'd0);
            unique case (r_state)
                SEARCH: begin
                    if (w_v_fall && !w_tmo) begin
                        r_state     <= TRACK;
                        r_good      <= '0;
                        r_frame_bad <= 1'b0;
                    end
                end
                TRACK: begin
                    if (w_tmo) begin
                        r_state <= SEARCH;
                        r_good  <= '0;
                    end else if (w_v_fall) begin
                        r_frame_bad <= 1'b0;
                        if (r_frame_bad || w_err) begin
                            r_good <= '0;
                        end else if (r_good == GOOD_LAST) begin
                            r_state <= LOCKED;
                            r_good  <= '0;
                        end else begin
                            r_good <= r_good + 4'd1;
                        end
                    end else if (w_h_bad) begin
                        r_good      <= '0;
                        r_frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_err) begin
                        r_state <= SEARCH;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;
    assign timing_err  = r_err;
    assign video_on    = r_locked && (r_h_cnt < 10'(HD))
                         && (r_v_cnt < 10'(VD));

endmodule
